// File: rtl/fft_pkg.sv
// fft_pkg: shared constants, types and helpers for the 16-point FFT datapath.
//   N_POINTS   samples per frame (power of two)
//   DATA_W     two's-complement width of each real/imag component
//   LOG2N      log2(N_POINTS), lane index width
//   bitrev()   reverse the LOG2N low bits of a lane index
package fft_pkg;

    localparam int unsigned N_POINTS = 16;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned LOG2N    = 4;
    localparam int unsigned CNT_W    = LOG2N + 1;

    // One complex sample as carried on the input stream
    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } sample_t;

    // Loader frame state: collecting samples, or holding a complete frame
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } load_state_t;

    // Bit-reversed lane index for radix-2 input ordering
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] idx);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < LOG2N; i++) begin
            r[i] = idx[LOG2N-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/toggle_detect.sv
// toggle_detect: registers a toggle-style handshake level and flags any
// change against the registered copy.
//   clk, rst   clock, synchronous active-high reset (registered level -> 0)
//   level      incoming toggle signal
//   level_q    registered copy of level
//   change_c   high in the cycle where level differs from level_q
module toggle_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic level_q,
    output logic change_c
);

    // Track the incoming level every cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign change_c = level != level_q;

endmodule

// File: rtl/fft_input_loader.sv
// fft_input_loader: collects a stream of complex samples into a frame buffer
// and hands complete frames to the 16-point FFT over its parallel lanes.
//   clk, rst                synchronous active-high reset
//   s_valid/s_ready         input sample handshake (s_ready combinational)
//   s_real, s_imag          sample components
//   frame_real, frame_imag  FFT lanes, lane k at [k*DATA_W +: DATA_W]
//   new_input_flag          toggles once per launched frame
//   fft_ready_flag          toggles once per completed transform
//   fft_busy                launched frame not yet completed
//   frames_launched         wrapping launch counter
// Build option: define FFT_LOADER_BITREV_EN to place sample k on lane
// bitrev(k); otherwise sample k goes to lane k.
module fft_input_loader
    import fft_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [DATA_W-1:0]          s_real,
    input  logic [DATA_W-1:0]          s_imag,
    output logic [N_POINTS*DATA_W-1:0] frame_real,
    output logic [N_POINTS*DATA_W-1:0] frame_imag,
    output logic                       new_input_flag,
    input  logic                       fft_ready_flag,
    output logic                       fft_busy,
    output logic [15:0]                frames_launched
);

    load_state_t                       state;
    load_state_t                       state_nxt;
    logic [CNT_W-1:0]                  fill_cnt;
    logic [N_POINTS-1:0][DATA_W-1:0]   fill_real;
    logic [N_POINTS-1:0][DATA_W-1:0]   fill_imag;
    logic [LOG2N-1:0]                  lane_c;
    sample_t                           sample_c;
    logic                              accept_c;
    logic                              launch_c;
    logic                              ready_q;
    logic                              ready_tgl_c;

    assign sample_c = {s_real, s_imag};
    assign s_ready  = !rst && (fill_cnt != CNT_W'(N_POINTS));

`ifdef FFT_LOADER_BITREV_EN
    assign lane_c = bitrev(fill_cnt[LOG2N-1:0]);
`else
    assign lane_c = fill_cnt[LOG2N-1:0];
`endif

    // Completion toggle from the FFT
    toggle_detect u_ready_det (
        .clk      (clk),
        .rst      (rst),
        .level    (fft_ready_flag),
        .level_q  (ready_q),
        .change_c (ready_tgl_c)
    );

    // Frame state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus accept/launch strobes; launch waits for the registered busy
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        launch_c  = 1'b0;
        case (state)
            ST_FILL: begin
                accept_c = s_valid && s_ready;
                if (accept_c && (fill_cnt == CNT_W'(N_POINTS - 1))) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!fft_busy) begin
                    launch_c  = 1'b1;
                    state_nxt = ST_FILL;
                end
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    // Fill buffer, frame lanes, busy tracking and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_cnt        <= '0;
            fill_real       <= '0;
            fill_imag       <= '0;
            frame_real      <= '0;
            frame_imag      <= '0;
            new_input_flag  <= 1'b0;
            fft_busy        <= 1'b0;
            frames_launched <= '0;
        end else begin
            if (accept_c) begin
                fill_real[lane_c] <= sample_c.re;
                fill_imag[lane_c] <= sample_c.im;
                fill_cnt          <= fill_cnt + CNT_W'(1);
            end
            if (launch_c) begin
                frame_real      <= fill_real;
                frame_imag      <= fill_imag;
                new_input_flag  <= ~new_input_flag;
                fill_cnt        <= '0;
                frames_launched <= frames_launched + 16'd1;
            end
            // A ready toggle while idle is ignored; a launch always marks busy
            if (launch_c) begin
                fft_busy <= 1'b1;
            end else if (ready_tgl_c) begin
                fft_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: directed stimulus for fft_input_loader with a
// queue-based frame model checked every cycle, plus literal spot checks.
module tb_fft_input_loader;

    localparam int NP = 16;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic [DW-1:0]     s_real;
    logic [DW-1:0]     s_imag;
    logic [NP*DW-1:0]  frame_real;
    logic [NP*DW-1:0]  frame_imag;
    logic              new_input_flag;
    logic              fft_ready_flag;
    logic              fft_busy;
    logic [15:0]       frames_launched;

    int n_chk  = 0;
    int n_fail = 0;

    fft_input_loader dut (
        .clk             (clk),
        .rst             (rst),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_real          (s_real),
        .s_imag          (s_imag),
        .frame_real      (frame_real),
        .frame_imag      (frame_imag),
        .new_input_flag  (new_input_flag),
        .fft_ready_flag  (fft_ready_flag),
        .fft_busy        (fft_busy),
        .frames_launched (frames_launched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Lane that receives the k-th sample of a frame
    function automatic int lane_of(input int k);
        int r;
`ifdef FFT_LOADER_BITREV_EN
        r = 0;
        for (int i = 0; i < 4; i++) begin
            if (((k >> i) & 1) != 0) r = r | (1 << (3 - i));
        end
`else
        r = k;
`endif
        return r;
    endfunction

    task automatic chk(input string name, input logic [NP*DW-1:0] act, input logic [NP*DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } smp_t;

    smp_t          pend[$];
    logic [DW-1:0] m_real [NP];
    logic [DW-1:0] m_imag [NP];
    bit            m_busy;
    bit            m_flag;
    bit            m_prev_rdy;
    logic [15:0]   m_launched;

    always @(posedge clk) begin
        bit launch;
        bit tgl;
        if (rst) begin
            pend.delete();
            m_busy     = 0;
            m_flag     = 0;
            m_prev_rdy = 0;
            m_launched = 16'd0;
            for (int k = 0; k < NP; k++) begin
                m_real[k] = '0;
                m_imag[k] = '0;
            end
        end else begin
            launch = (pend.size() == NP) && !m_busy;
            tgl    = (fft_ready_flag != m_prev_rdy);
            if (s_valid && pend.size() < NP) pend.push_back('{re: s_real, im: s_imag});
            if (launch) begin
                for (int k = 0; k < NP; k++) begin
                    m_real[lane_of(k)] = pend[k].re;
                    m_imag[lane_of(k)] = pend[k].im;
                end
                pend.delete();
                m_flag     = !m_flag;
                m_busy     = 1;
                m_launched = m_launched + 16'd1;
            end else if (tgl) begin
                m_busy = 0;
            end
            m_prev_rdy = fft_ready_flag;
        end
    end

    // Per-cycle comparison, away from both clock edges
    always @(posedge clk) begin
        logic [NP*DW-1:0] er;
        logic [NP*DW-1:0] ei;
        #3;
        for (int k = 0; k < NP; k++) begin
            er[k*DW +: DW] = m_real[k];
            ei[k*DW +: DW] = m_imag[k];
        end
        chk("cyc_s_ready", NP*DW'(s_ready), NP*DW'(!rst && pend.size() != NP));
        chk("cyc_flag", NP*DW'(new_input_flag), NP*DW'(m_flag));
        chk("cyc_busy", NP*DW'(fft_busy), NP*DW'(m_busy));
        chk("cyc_launched", NP*DW'(frames_launched), NP*DW'(m_launched));
        chk("cyc_frame_real", frame_real, er);
        chk("cyc_frame_imag", frame_imag, ei);
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [DW-1:0] re, input logic [DW-1:0] im);
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_real  = re;
        s_imag  = im;
        while (!s_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: s_ready stayed 0 for %0d cycles", guard);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    function automatic logic [DW-1:0] lane_r(input int k);
        return frame_real[k*DW +: DW];
    endfunction

    function automatic logic [DW-1:0] lane_i(input int k);
        return frame_imag[k*DW +: DW];
    endfunction

    // ---------------- directed sequence ----------------
    initial begin
        rst            = 1'b1;
        s_valid        = 1'b0;
        s_real         = '0;
        s_imag         = '0;
        fft_ready_flag = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", NP*DW'(s_ready), '0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_s_ready", NP*DW'(s_ready), NP*DW'(1));
        chk("post_rst_launched", NP*DW'(frames_launched), '0);
        chk("post_rst_busy", NP*DW'(fft_busy), '0);
        chk("post_rst_frame", frame_real, '0);

        // Basic frame: real=100+k, imag=-k
        for (int k = 0; k < NP; k++) send(DW'(100 + k), DW'(-k));
        chk("basic_flag_not_early", NP*DW'(new_input_flag), '0);
        @(negedge clk);
        chk("basic_flag", NP*DW'(new_input_flag), NP*DW'(1));
`ifdef FFT_LOADER_BITREV_EN
        chk("basic_lane5_re", NP*DW'(lane_r(5)), NP*DW'(110));
        chk("basic_lane5_im", NP*DW'(lane_i(5)), NP*DW'(16'hFFF6));
`else
        chk("basic_lane5_re", NP*DW'(lane_r(5)), NP*DW'(105));
        chk("basic_lane5_im", NP*DW'(lane_i(5)), NP*DW'(16'hFFFB));
`endif
        chk("basic_launched", NP*DW'(frames_launched), NP*DW'(1));
        chk("basic_busy", NP*DW'(fft_busy), NP*DW'(1));
        chk("basic_s_ready", NP*DW'(s_ready), NP*DW'(1));

        // Backpressure: frame 2 fills while the FFT stays busy
        for (int k = 0; k < NP; k++) send(DW'(200 + k), DW'(k));
        repeat (3) @(negedge clk);
        chk("bp_s_ready", NP*DW'(s_ready), '0);
        chk("bp_flag_held", NP*DW'(new_input_flag), NP*DW'(1));
        chk("bp_launched", NP*DW'(frames_launched), NP*DW'(1));
`ifdef FFT_LOADER_BITREV_EN
        chk("bp_frame1_held", NP*DW'(lane_r(5)), NP*DW'(110));
`else
        chk("bp_frame1_held", NP*DW'(lane_r(5)), NP*DW'(105));
`endif
        fft_ready_flag = 1'b1;
        @(negedge clk);
        chk("bp_busy_cleared", NP*DW'(fft_busy), '0);
        chk("bp_flag_not_yet", NP*DW'(new_input_flag), NP*DW'(1));
        @(negedge clk);
        chk("bp_flag_back", NP*DW'(new_input_flag), '0);
        chk("bp_launched2", NP*DW'(frames_launched), NP*DW'(2));
        chk("bp_busy2", NP*DW'(fft_busy), NP*DW'(1));
`ifdef FFT_LOADER_BITREV_EN
        chk("bp_frame2_lane5", NP*DW'(lane_r(5)), NP*DW'(210));
`else
        chk("bp_frame2_lane5", NP*DW'(lane_r(5)), NP*DW'(205));
`endif

        // Complete frame 2, then two spurious toggles while idle
        fft_ready_flag = 1'b0;
        @(negedge clk);
        chk("done2_busy", NP*DW'(fft_busy), '0);
        fft_ready_flag = 1'b1;
        @(negedge clk);
        fft_ready_flag = 1'b0;
        repeat (2) @(negedge clk);
        chk("spur_busy", NP*DW'(fft_busy), '0);
        chk("spur_launched", NP*DW'(frames_launched), NP*DW'(2));
        chk("spur_flag", NP*DW'(new_input_flag), '0);

        // Gapped input
        for (int k = 0; k < NP; k++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send(DW'(300 + k), DW'(-3 * k));
        end
        chk("gap_flag_not_early", NP*DW'(new_input_flag), '0);
        @(negedge clk);
        chk("gap_flag", NP*DW'(new_input_flag), NP*DW'(1));
        chk("gap_launched", NP*DW'(frames_launched), NP*DW'(3));

        // Reset mid-fill, then a fresh frame with real=k
        for (int k = 0; k < 7; k++) send(DW'(400 + k), DW'(k));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_launched", NP*DW'(frames_launched), '0);
        chk("rst2_busy", NP*DW'(fft_busy), '0);
        for (int k = 0; k < NP; k++) send(DW'(k), DW'(50 + k));
        @(negedge clk);
        chk("rst2_launched1", NP*DW'(frames_launched), NP*DW'(1));
        chk("rst2_lane0", NP*DW'(lane_r(0)), '0);
`ifdef FFT_LOADER_BITREV_EN
        chk("lane8_re", NP*DW'(lane_r(8)), NP*DW'(1));
        chk("lane12_re", NP*DW'(lane_r(12)), NP*DW'(3));
`else
        chk("lane8_re", NP*DW'(lane_r(8)), NP*DW'(8));
        chk("lane12_re", NP*DW'(lane_r(12)), NP*DW'(12));
`endif
        chk("lane15_re", NP*DW'(lane_r(15)), NP*DW'(15));

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
